// File: rtl/uc_pila.sv
// uc_pila: stack-aware control unit for the single-cycle processor.
// Decodes opcode/zero flag into datapath selects and enables, and
// implements JAL/RET through an internal return-address stack.
//
// Optional feature macro: UC_STACK_CHECK_EN
//   defined   : overflow/underflow detection with RUN/FAULT state machine
//   undefined : no FAULT state, stack pointer wraps modulo DEPTH
//
// Parameters:
//   PC_W  - width of PC / return addresses
//   DEPTH - return-stack entries (>=2; power of two without the checker)
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   opcode, z           - instruction opcode, registered zero flag
//   pc_plus1            - next sequential PC, pushed by JAL
//   s_inc, s_inm        - PC-increment select, immediate write-back select
//   we3, wez            - register-file / zero-flag write enables
//   op_alu              - ALU operation (opcode[4:2])
//   s_ret, ret_addr     - return select and top-of-stack address
//   pc_en               - PC load enable
//   fault               - processor frozen on stack error
module uc_pila #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      opcode,
  input  logic            z,
  input  logic [PC_W-1:0] pc_plus1,
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [2:0]      op_alu,
  output logic            s_ret,
  output logic [PC_W-1:0] ret_addr,
  output logic            pc_en,
  output logic            fault
);

`ifdef UC_STACK_CHECK_EN
  localparam int SP_W = $clog2(DEPTH + 1);
`else
  localparam int SP_W = $clog2(DEPTH);
`endif
  localparam int IDX_W = $clog2(DEPTH);

  logic [PC_W-1:0]  stack [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic [3:0] ctrl;      // {s_inc, s_inm, we3, wez} before gating
  logic       is_jal;
  logic       is_ret;
  logic       run;       // instruction is allowed to take effect this cycle
  logic       push;
  logic       pop;

  // Opcode decode
  always_comb begin
    ctrl   = 4'b1000;
    is_jal = 1'b0;
    is_ret = 1'b0;
    casez (opcode)
      6'b0?????: ctrl = 4'b1011;
      6'b1000??: ctrl = 4'b1110;
      6'b100100: ctrl = z ? 4'b0000 : 4'b1000;
      6'b100101: ctrl = z ? 4'b1000 : 4'b0000;
      6'b100110: ctrl = 4'b0000;
      6'b100111: begin
        ctrl   = 4'b0000;
        is_jal = 1'b1;
      end
      6'b101000: begin
        ctrl   = 4'b1000;
        is_ret = 1'b1;
      end
      default:   ctrl = 4'b1000;
    endcase
  end

`ifdef UC_STACK_CHECK_EN
  typedef enum logic {RUN, FAULT} state_t;
  state_t state, state_nxt;
  logic   full, empty, err;

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign err    = (is_jal && full) || (is_ret && empty);
  assign run    = reset_n && (state == RUN) && !err;
  assign fault  = (state == FAULT);
  assign wr_idx = IDX_W'(sp);
  // sp=0 has no readable entry; steer the read to a legal index
  assign rd_idx = (sp == '0) ? '0 : IDX_W'(sp - SP_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && err) state_nxt = FAULT;
  end
`else
  assign run    = reset_n;
  assign fault  = 1'b0;
  assign wr_idx = sp;
  assign rd_idx = sp - IDX_W'(1);   // wraps to DEPTH-1 on empty
`endif

  assign push = run && is_jal;
  assign pop  = run && is_ret;

  assign s_inc    = ctrl[3];
  assign s_inm    = ctrl[2];
  assign we3      = ctrl[1] && run;
  assign wez      = ctrl[0] && run;
  assign op_alu   = opcode[4:2];
  assign s_ret    = is_ret && run;
  assign pc_en    = run;
  assign ret_addr = stack[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  sp <= '0;
    else if (push) sp <= sp + SP_W'(1);
    else if (pop)  sp <= sp - SP_W'(1);
  end

  // Stack contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_plus1;
  end

endmodule

// File: tb/tb_uc_pila.sv
// Directed self-checking bench for uc_pila. Exercises reset, decode,
// call/return and either the fault checker (UC_STACK_CHECK_EN, DEPTH=8)
// or the wrapping stack (default build, DEPTH=4).
module tb_uc_pila;

  localparam int PC_W = 10;
`ifdef UC_STACK_CHECK_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 4;
`endif

  logic            clk;
  logic            reset_n;
  logic [5:0]      opcode;
  logic            z;
  logic [PC_W-1:0] pc_plus1;
  logic            s_inc, s_inm, we3, wez, s_ret, pc_en, fault;
  logic [2:0]      op_alu;
  logic [PC_W-1:0] ret_addr;
  logic [3:0]      ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] OP_ARI = 6'b000000;
  localparam logic [5:0] OP_LI  = 6'b100010;
  localparam logic [5:0] OP_BZ  = 6'b100100;
  localparam logic [5:0] OP_BNZ = 6'b100101;
  localparam logic [5:0] OP_J   = 6'b100110;
  localparam logic [5:0] OP_JAL = 6'b100111;
  localparam logic [5:0] OP_RET = 6'b101000;
  localparam logic [5:0] OP_NOP = 6'b111111;

  uc_pila #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .opcode   (opcode),
    .z        (z),
    .pc_plus1 (pc_plus1),
    .s_inc    (s_inc),
    .s_inm    (s_inm),
    .we3      (we3),
    .wez      (wez),
    .op_alu   (op_alu),
    .s_ret    (s_ret),
    .ret_addr (ret_addr),
    .pc_en    (pc_en),
    .fault    (fault)
  );

  assign ctrl = {s_inc, s_inm, we3, wez};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction while clk is low; it executes on the next rising edge.
  task automatic apply(input logic [5:0] op, input logic zz, input logic [PC_W-1:0] pc);
    @(negedge clk);
    opcode   = op;
    z        = zz;
    pc_plus1 = pc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    opcode  = OP_ARI;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    opcode   = OP_ARI;
    z        = 1'b0;
    pc_plus1 = '0;

    // Reset
    @(negedge clk);
    #1;
    check("rst_pc_en", 32'(pc_en), 0);
    check("rst_we3",   32'(we3),   0);
    check("rst_wez",   32'(wez),   0);
    check("rst_fault", 32'(fault), 0);
    check("rst_s_ret", 32'(s_ret), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Decode
    apply(OP_ARI, 1'b0, 10'h000);
    check("ari_ctrl",   32'(ctrl),   'b1011);
    check("ari_op_alu", 32'(op_alu), 0);
    check("ari_pc_en",  32'(pc_en),  1);
    apply(6'b011100, 1'b1, 10'h000);
    check("ari2_ctrl",   32'(ctrl),   'b1011);
    check("ari2_op_alu", 32'(op_alu), 'b111);
    apply(OP_LI, 1'b0, 10'h000);
    check("li_ctrl",    32'(ctrl),   'b1110);
    apply(OP_BZ, 1'b1, 10'h000);
    check("bz_z1",      32'(ctrl),   'b0000);
    check("bz_op_alu",  32'(op_alu), 'b001);
    apply(OP_BZ, 1'b0, 10'h000);
    check("bz_z0",      32'(ctrl),   'b1000);
    apply(OP_BNZ, 1'b0, 10'h000);
    check("bnz_z0",     32'(ctrl),   'b0000);
    apply(OP_BNZ, 1'b1, 10'h000);
    check("bnz_z1",     32'(ctrl),   'b1000);
    apply(OP_J, 1'b0, 10'h000);
    check("j_z0",       32'(ctrl),   'b0000);
    apply(OP_J, 1'b1, 10'h000);
    check("j_z1",       32'(ctrl),   'b0000);
    check("j_s_ret",    32'(s_ret),  0);
    apply(OP_NOP, 1'b0, 10'h000);
    check("nop_ctrl",   32'(ctrl),   'b1000);
    check("nop_pc_en",  32'(pc_en),  1);

    // Call / return
    apply(OP_JAL, 1'b0, 10'h005);
    check("jal1_ctrl",  32'(ctrl),   'b0000);
    check("jal1_pc_en", 32'(pc_en),  1);
    check("jal1_s_ret", 32'(s_ret),  0);
    apply(OP_JAL, 1'b0, 10'h012);
    check("jal2_ctrl",  32'(ctrl),   'b0000);
    apply(OP_RET, 1'b0, 10'h000);
    check("ret1_s_ret", 32'(s_ret),    1);
    check("ret1_addr",  32'(ret_addr), 'h012);
    check("ret1_ctrl",  32'(ctrl),     'b1000);
    apply(OP_RET, 1'b0, 10'h000);
    check("ret2_s_ret", 32'(s_ret),    1);
    check("ret2_addr",  32'(ret_addr), 'h005);
    apply(OP_NOP, 1'b0, 10'h000);
    check("cr_sp", 32'(dut.sp), 0);

`ifdef UC_STACK_CHECK_EN
    // Overflow
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(OP_JAL, 1'b0, PC_W'(10'h100 + i));
      check("ovf_fill_pc_en", 32'(pc_en), 1);
    end
    apply(OP_JAL, 1'b0, 10'h3ff);
    check("ovf_top",     32'(ret_addr), 'h107);
    check("ovf_pc_en",   32'(pc_en),    0);
    check("ovf_we3",     32'(we3),      0);
    check("ovf_s_ret",   32'(s_ret),    0);
    check("ovf_fault0",  32'(fault),    0);
    for (int i = 0; i < 10; i++) begin
      apply((i % 2 == 0) ? OP_ARI : OP_RET, 1'b0, 10'h000);
      check("ovf_fault",  32'(fault), 1);
      check("ovf_f_we3",  32'(we3),   0);
      check("ovf_f_pc",   32'(pc_en), 0);
      check("ovf_f_sret", 32'(s_ret), 0);
    end
    check("ovf_sp", 32'(dut.sp), 8);

    // Underflow
    do_reset();
    apply(OP_RET, 1'b0, 10'h000);
    check("udf_pc_en",  32'(pc_en), 0);
    check("udf_s_ret",  32'(s_ret), 0);
    check("udf_fault0", 32'(fault), 0);
    apply(OP_ARI, 1'b0, 10'h000);
    check("udf_fault",  32'(fault), 1);
    check("udf_we3",    32'(we3),   0);
    reset_n = 1'b0;
    #1;
    check("udf_rst_fault", 32'(fault),  0);
    check("udf_rst_sp",    32'(dut.sp), 0);
    check("udf_rst_pc_en", 32'(pc_en),  0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(OP_ARI, 1'b0, 10'h000);
    check("udf_rel_pc_en", 32'(pc_en), 1);
    check("udf_rel_fault", 32'(fault), 0);
`else
    // Wrapping stack, DEPTH=4
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      apply(OP_JAL, 1'b0, PC_W'(i));
      check("wrap_jal_pc_en", 32'(pc_en), 1);
      check("wrap_jal_fault", 32'(fault), 0);
    end
    apply(OP_RET, 1'b0, 10'h000);
    check("wrap_ret0", 32'(ret_addr), 5);
    apply(OP_RET, 1'b0, 10'h000);
    check("wrap_ret1", 32'(ret_addr), 4);
    apply(OP_RET, 1'b0, 10'h000);
    check("wrap_ret2", 32'(ret_addr), 3);
    apply(OP_RET, 1'b0, 10'h000);
    check("wrap_ret3", 32'(ret_addr), 2);
    apply(OP_RET, 1'b0, 10'h000);
    check("wrap_ret4",   32'(ret_addr), 5);
    check("wrap_s_ret",  32'(s_ret),    1);
    check("wrap_pc_en",  32'(pc_en),    1);
    apply(OP_NOP, 1'b0, 10'h000);
    check("wrap_fault",  32'(fault),    0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
